// File: rtl/alu_exec_stage.sv
// ALU execute stage with a single-entry registered output and condition codes.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - upstream offers an operation
//   in_ready   - stage can accept an operation this cycle
//   ifun       - operation: 0=ADD, 1=SUB, 2=AND, 3=XOR (result is valB op valA)
//   valA, valB - 64-bit operands
//   set_cc     - update {ZF,SF,OF} from this operation
//   cond       - condition select, evaluated against the pre-update condition codes
//   out_valid  - result register holds a valid result
//   out_ready  - downstream consumes the result this cycle
//   valE       - registered ALU result
//   cnd        - registered condition outcome
//   cc         - condition-code register {ZF,SF,OF}
module alu_exec_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic        set_cc,
  input  logic [2:0]  cond,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] valE,
  output logic        cnd,
  output logic [2:0]  cc
);

  localparam logic [2:0] CcReset = 3'b100;

  logic        out_valid_q, out_valid_d;
  logic [63:0] val_e_q, val_e_d;
  logic        cnd_q, cnd_d;
  logic [2:0]  cc_q, cc_d;

  logic [63:0] alu_res;
  logic        alu_of;
  logic        cond_hit;
  logic        accept;
  logic        zf_old, sf_old, of_old;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign valE      = val_e_q;
  assign cnd       = cnd_q;
  assign cc        = cc_q;

  // ALU datapath and overflow detection.
  always_comb begin
    alu_res = 64'd0;
    alu_of  = 1'b0;
    case (ifun)
      2'd0: begin
        alu_res = valB + valA;
        alu_of  = (valA[63] == valB[63]) && (alu_res[63] != valB[63]);
      end
      2'd1: begin
        alu_res = valB - valA;
        alu_of  = (valA[63] != valB[63]) && (alu_res[63] != valB[63]);
      end
      2'd2: alu_res = valB & valA;
      default: alu_res = valB ^ valA;
    endcase
  end

  // Condition uses the codes as they stood before this operation's update.
  always_comb begin
    zf_old   = cc_q[2];
    sf_old   = cc_q[1];
    of_old   = cc_q[0];
    cond_hit = 1'b1;
    case (cond)
      3'd1:    cond_hit = (sf_old ^ of_old) | zf_old;
      3'd2:    cond_hit = sf_old ^ of_old;
      3'd3:    cond_hit = zf_old;
      3'd4:    cond_hit = !zf_old;
      3'd5:    cond_hit = !(sf_old ^ of_old);
      3'd6:    cond_hit = !(sf_old ^ of_old) && !zf_old;
      default: cond_hit = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    val_e_d     = val_e_q;
    cnd_d       = cnd_q;
    cc_d        = cc_q;
    if (accept) begin
      // Covers simultaneous consume+accept: result replaced, valid stays high.
      out_valid_d = 1'b1;
      val_e_d     = alu_res;
      cnd_d       = cond_hit;
      if (set_cc) begin
        cc_d = {(alu_res == 64'd0), alu_res[63], alu_of};
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      val_e_q     <= 64'd0;
      cnd_q       <= 1'b0;
      cc_q        <= CcReset;
    end else begin
      out_valid_q <= out_valid_d;
      val_e_q     <= val_e_d;
      cnd_q       <= cnd_d;
      cc_q        <= cc_d;
    end
  end

endmodule
